// File: rtl/axil_regfile_s.sv
`timescale 1ns/1ps
// AXI4-Lite register bank: buffered AW/W with strobe-merged commits, single-beat reads,
// whole bank exported flat plus a one-cycle commit pulse for fabric logic.
module axil_regfile_s #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [2:0]                       s_axi_awprot,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [2:0]                       s_axi_arprot,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
  output logic                             wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]      wr_idx,
  output logic [DATA_WIDTH-1:0]            wr_data
);
  localparam int                    IW   = $clog2(NUM_REGS);
  localparam int                    SW   = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS*4);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                  aw_hit, ar_hit;
  logic [IW-1:0]         aw_idx, ar_idx;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_ok;

  // Write decode works on the buffered address; read decode on the live AR address.
  assign aw_off = awaddr_q - BASE_ADDR;
  assign aw_hit = (awaddr_q >= BASE_ADDR) && (aw_off < SPAN);
  assign aw_idx = aw_off[IW+1:2];
  assign ar_off = s_axi_araddr - BASE_ADDR;
  assign ar_hit = (s_axi_araddr >= BASE_ADDR) && (ar_off < SPAN);
  assign ar_idx = ar_off[IW+1:2];

  assign aw_hs  = s_axi_awvalid & awready_q;
  assign w_hs   = s_axi_wvalid & wready_q;
  assign ar_hs  = s_axi_arvalid & arready_q;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  always_comb begin
    merged = regs_q[aw_idx];
    for (int b = 0; b < SW; b++)
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
  end

  always_comb begin
    regs_d     = regs_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    wr_pulse_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_hit ? 2'b00 : 2'b10;
      if (aw_hit) begin
        regs_d[aw_idx] = merged;
        wr_pulse_d     = 1'b1;
        wr_idx_d       = aw_idx;
        wr_data_d      = merged;
      end
    end

    // Reads sample regs_q, so a same-edge commit is not visible to this read.
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_hit ? regs_q[ar_idx] : '0;
      rresp_d  = ar_hit ? 2'b00 : 2'b10;
    end

    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      regs_q     <= '0;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      wr_pulse_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign reg_q         = regs_q;
  assign wr_pulse      = wr_pulse_q;
  assign wr_idx        = wr_idx_q;
  assign wr_data       = wr_data_q;

  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, aw_off, ar_off};
endmodule

// File: tb/tb_axil_regfile_s.sv
`timescale 1ns/1ps
// Directed bench for axil_regfile_s: hand-computed register images and responses per scenario.
module tb_axil_regfile_s;
  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  awaddr, wdata, araddr;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, wr_data;
  logic [511:0] reg_q;
  logic         wr_pulse;
  logic [3:0]   wr_idx;

  logic [511:0] exp_regs;
  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  r_resp;
  logic        r_pulse;
  logic [3:0]  r_idx;
  logic [31:0] r_data;

  axil_regfile_s dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_idx(wr_idx), .wr_data(wr_data)
  );

  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic pulse,
                          output logic [3:0] idx, output logic [31:0] wd);
    logic aw_done, w_done, aw_hs, w_hs;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick; n++;
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick; n++; end
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL write_timeout addr=%h bvalid=%b want 1", a, bvalid);
    end
    resp = bresp; pulse = wr_pulse; idx = wr_idx; wd = wr_data;
    bready = 1'b1; tick; bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic done, hs;
    int n;
    araddr = a; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 50) begin
      hs = arvalid && arready;
      tick; n++;
      if (hs) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_timeout addr=%h rvalid=%b want 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1; tick; rready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (5) tick;
    n_checks++; if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready got aw=%b w=%b ar=%b want 000", awready, wready, arready); end
    n_checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0 || wr_pulse !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid got b=%b r=%b pulse=%b want 000", bvalid, rvalid, wr_pulse); end
    n_checks++; if (reg_q !== '0 || rdata !== 32'h0) begin n_fail++;
      $display("FAIL reset_regs got reg_q=%h rdata=%h want 0", reg_q, rdata); end
    aresetn = 1'b1;
    tick;
    n_checks++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin n_fail++;
      $display("FAIL release_ready got aw=%b w=%b ar=%b want 111", awready, wready, arready); end
  endtask

  task automatic test_basic_write;
    do_write(32'h4, 32'h1010_1111, 4'hF, r_resp, r_pulse, r_idx, r_data);
    exp_regs[63:32] = 32'h1010_1111;
    n_checks++; if (r_resp !== 2'b00 || r_pulse !== 1'b1 || r_idx !== 4'd1 || r_data !== 32'h1010_1111) begin
      n_fail++; $display("FAIL basic_write got resp=%b pulse=%b idx=%0d data=%h want 00 1 1 10101111",
                         r_resp, r_pulse, r_idx, r_data); end
    n_checks++; if (wr_pulse !== 1'b0) begin n_fail++;
      $display("FAIL pulse_width got wr_pulse=%b want 0", wr_pulse); end
    n_checks++; if (reg_q !== exp_regs) begin n_fail++;
      $display("FAIL basic_regq got %h want %h", reg_q, exp_regs); end
    do_read(32'h4, r_data, r_resp);
    n_checks++; if (r_data !== 32'h1010_1111 || r_resp !== 2'b00) begin n_fail++;
      $display("FAIL basic_read got %h/%b want 10101111/00", r_data, r_resp); end
  endtask

  task automatic test_strobes;
    do_write(32'h8, 32'hAAAA_BBBB, 4'hF, r_resp, r_pulse, r_idx, r_data);
    do_write(32'h8, 32'h0101_0000, 4'b0101, r_resp, r_pulse, r_idx, r_data);
    exp_regs[95:64] = 32'hAA01_BB00;
    n_checks++; if (r_data !== 32'hAA01_BB00 || r_idx !== 4'd2) begin n_fail++;
      $display("FAIL strobe_wrdata got %h idx %0d want aa01bb00 idx 2", r_data, r_idx); end
    n_checks++; if (reg_q !== exp_regs) begin n_fail++;
      $display("FAIL strobe_regq got %h want %h", reg_q, exp_regs); end
  endtask

  task automatic test_ordering;
    // W first, AW three cycles later
    awaddr = 32'h14; wdata = 32'h5555_0005; wstrb = 4'hF; wvalid = 1'b1;
    tick; wvalid = 1'b0;
    n_checks++; if (wready !== 1'b0) begin n_fail++;
      $display("FAIL w_first_wready got %b want 0", wready); end
    repeat (3) tick;
    n_checks++; if (bvalid !== 1'b0 || wr_pulse !== 1'b0) begin n_fail++;
      $display("FAIL w_first_nocommit got b=%b pulse=%b want 0 0", bvalid, wr_pulse); end
    awvalid = 1'b1; tick; awvalid = 1'b0;
    n_checks++; if (bvalid !== 1'b0) begin n_fail++;
      $display("FAIL w_first_early got bvalid=%b want 0", bvalid); end
    tick;
    exp_regs[191:160] = 32'h5555_0005;
    n_checks++; if (bvalid !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd5 || reg_q !== exp_regs) begin
      n_fail++; $display("FAIL w_first_commit got b=%b pulse=%b idx=%0d regs=%h", bvalid, wr_pulse, wr_idx, reg_q); end
    bready = 1'b1; tick; bready = 1'b0;

    // AW first, then W; keep B unacknowledged across a second transaction
    awaddr = 32'h18; awvalid = 1'b1; tick; awvalid = 1'b0;
    n_checks++; if (awready !== 1'b0 || bvalid !== 1'b0) begin n_fail++;
      $display("FAIL aw_first_hold got awready=%b bvalid=%b want 0 0", awready, bvalid); end
    wdata = 32'h6666_0006; wvalid = 1'b1; tick; wvalid = 1'b0;
    tick;
    exp_regs[223:192] = 32'h6666_0006;
    n_checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_q !== exp_regs) begin n_fail++;
      $display("FAIL aw_first_commit got b=%b resp=%b regs=%h", bvalid, bresp, reg_q); end
    awaddr = 32'h1C; wdata = 32'h7777_0007; awvalid = 1'b1; wvalid = 1'b1;
    tick; awvalid = 1'b0; wvalid = 1'b0;
    repeat (4) tick;
    n_checks++; if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1 || wr_pulse !== 1'b0
                    || reg_q !== exp_regs) begin n_fail++;
      $display("FAIL stall got aw=%b w=%b b=%b pulse=%b regs=%h", awready, wready, bvalid, wr_pulse, reg_q); end
    bready = 1'b1; tick; bready = 1'b0;
    n_checks++; if (bvalid !== 1'b0 || reg_q !== exp_regs) begin n_fail++;
      $display("FAIL stall_bclear got b=%b regs=%h want 0", bvalid, reg_q); end
    tick;
    exp_regs[255:224] = 32'h7777_0007;
    n_checks++; if (bvalid !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd7 || reg_q !== exp_regs) begin
      n_fail++; $display("FAIL stall_commit got b=%b pulse=%b idx=%0d regs=%h", bvalid, wr_pulse, wr_idx, reg_q); end
    bready = 1'b1; tick; bready = 1'b0;
  endtask

  task automatic test_out_of_range;
    do_write(32'h1010_1111, 32'hDEAD_BEEF, 4'hF, r_resp, r_pulse, r_idx, r_data);
    n_checks++; if (r_resp !== 2'b10 || r_pulse !== 1'b0) begin n_fail++;
      $display("FAIL oor_write got resp=%b pulse=%b want 10 0", r_resp, r_pulse); end
    n_checks++; if (reg_q !== exp_regs) begin n_fail++;
      $display("FAIL oor_regq got %h want %h", reg_q, exp_regs); end
    do_read(32'h1010_1111, r_data, r_resp);
    n_checks++; if (r_data !== 32'h0 || r_resp !== 2'b10) begin n_fail++;
      $display("FAIL oor_read got %h/%b want 0/10", r_data, r_resp); end
    // last register via an unaligned byte address, then one past the end
    do_write(32'h3F, 32'h0000_00A5, 4'b0001, r_resp, r_pulse, r_idx, r_data);
    exp_regs[511:480] = 32'h0000_00A5;
    n_checks++; if (r_resp !== 2'b00 || r_idx !== 4'd15 || reg_q !== exp_regs) begin n_fail++;
      $display("FAIL last_reg got resp=%b idx=%0d regs=%h", r_resp, r_idx, reg_q); end
    do_read(32'h40, r_data, r_resp);
    n_checks++; if (r_data !== 32'h0 || r_resp !== 2'b10) begin n_fail++;
      $display("FAIL past_end got %h/%b want 0/10", r_data, r_resp); end
    do_read(32'h3C, r_data, r_resp);
    n_checks++; if (r_data !== 32'h0000_00A5 || r_resp !== 2'b00) begin n_fail++;
      $display("FAIL last_read got %h/%b want a5/00", r_data, r_resp); end
  endtask

  task automatic test_collision;
    do_write(32'hC, 32'h1111_0000, 4'hF, r_resp, r_pulse, r_idx, r_data);
    awaddr = 32'hC; wdata = 32'h5AA5_A55A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick; awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    tick; arvalid = 1'b0;
    exp_regs[127:96] = 32'h5AA5_A55A;
    n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1111_0000 || bvalid !== 1'b1) begin n_fail++;
      $display("FAIL collision got rvalid=%b rdata=%h bvalid=%b want 1 11110000 1", rvalid, rdata, bvalid); end
    n_checks++; if (reg_q !== exp_regs) begin n_fail++;
      $display("FAIL collision_regq got %h want %h", reg_q, exp_regs); end
    rready = 1'b1; bready = 1'b1; tick; rready = 1'b0; bready = 1'b0;
    do_read(32'hC, r_data, r_resp);
    n_checks++; if (r_data !== 32'h5AA5_A55A || r_resp !== 2'b00) begin n_fail++;
      $display("FAIL collision_after got %h/%b want 5aa5a55a/00", r_data, r_resp); end
  endtask

  task automatic test_reset_mid;
    awaddr = 32'h4; wdata = 32'h3333_3333; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick; awvalid = 1'b0; wvalid = 1'b0;
    tick;
    araddr = 32'h4; arvalid = 1'b1; tick; arvalid = 1'b0;
    tick;
    n_checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h3333_3333 || rresp !== 2'b00) begin
      n_fail++; $display("FAIL pending_hold got r=%b b=%b rdata=%h rresp=%b", rvalid, bvalid, rdata, rresp); end
    aresetn = 1'b0; tick;
    n_checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0 || rdata !== 32'h0 || wr_pulse !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valid got r=%b b=%b rdata=%h pulse=%b", rvalid, bvalid, rdata, wr_pulse); end
    n_checks++; if (reg_q !== '0 || awready !== 1'b0 || arready !== 1'b0 || wready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_regs got regs=%h aw=%b w=%b ar=%b", reg_q, awready, wready, arready); end
    tick;
    aresetn = 1'b1; tick;
    n_checks++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_release got aw=%b w=%b ar=%b b=%b", awready, wready, arready, bvalid); end
  endtask

  initial begin
    aresetn = 1'b0; awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    exp_regs = '0;
    test_reset;
    test_basic_write;
    test_strobes;
    test_ordering;
    test_out_of_range;
    test_collision;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_regfile_s.md
# axil_regfile_s

AXI4-Lite slave (responder) that terminates the `axis_lite_m` master's bus in a bank of 32-bit control/status registers. It accepts independent write-address and write-data handshakes and merges write strobes into the addressed register. Read and write responses are returned with OKAY/SLVERR status. The whole register bank is exported flat to fabric logic, and every committed write is also signalled as a one-cycle pulse.

## Interface
- `ADDR_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 32, data width; only 32 supported
- `NUM_REGS`, 16, number of registers; a power of two, 2..256
- `BASE_ADDR`, 32'h0000_0000, byte address of register 0; aligned to `NUM_REGS*4`
- `aclk` in 1: single clock; all logic on rising edge
- `aresetn` in 1: synchronous, active-low reset
- `s_axi_awaddr` in `ADDR_WIDTH`; `s_axi_awprot` in 3 (ignored); `s_axi_awvalid` in 1; `s_axi_awready` out 1
- `s_axi_wdata` in 32; `s_axi_wstrb` in 4; `s_axi_wvalid` in 1; `s_axi_wready` out 1
- `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1
- `s_axi_araddr` in `ADDR_WIDTH`; `s_axi_arprot` in 3 (ignored); `s_axi_arvalid` in 1; `s_axi_arready` out 1
- `s_axi_rdata` out 32; `s_axi_rresp` out 2; `s_axi_rvalid` out 1; `s_axi_rready` in 1
- `reg_q` out `NUM_REGS*32`: register contents, reg i at bits [32i+31:32i]
- `wr_pulse` out 1: high for one cycle when a write commits
- `wr_idx` out `$clog2(NUM_REGS)`: register index of the committed write
- `wr_data` out 32: post-merge value of the committed register

## Operation
- **Decode.**
  - `off = addr - BASE_ADDR`.
  - A hit requires `addr >= BASE_ADDR` and `off < NUM_REGS*4`.
  - `idx = off[$clog2(NUM_REGS)+1:2]`; `addr[1:0]` is ignored.
- **AW buffer.**
  - One-entry holding register with flag `aw_full`; `s_axi_awready = ~aw_full` (registered).
  - Captures address on an AW handshake.
- **W buffer.**
  - Same structure: `wready = ~w_full`.
  - Captures data and strobe.
  - AW and W may arrive in either order or in the same cycle.
- **Write commit.**
  - Condition: on the edge where `aw_full & w_full & ~s_axi_bvalid`.
  - On a hit: bytes with strobe=1 are written to the register and the rest keep their value; `bresp=2'b00`.
  - On a miss: no register changes; `bresp=2'b10` (SLVERR).
  - On the same edge: both buffers clear, `bvalid` is set, and `wr_pulse/wr_idx/wr_data` are driven for one cycle (hits only).
- **B channel.** `bvalid` holds until `bready`; it clears on the edge where `bvalid & bready`.
- **Read.**
  - `arready = ~rvalid`.
  - On an AR handshake, `rdata` is loaded with `reg[idx]` (hit, `rresp=00`) or 32'h0 (miss, `rresp=10`), and `rvalid` is set.
  - `rvalid`, `rdata` and `rresp` hold stable until `rready`.
- **Read/write collision.** When an AR handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
- **Reset (`aresetn=0` at an edge).**
  - All registers = 0; buffers empty; `bvalid=rvalid=0`; `bresp=rresp=0`; `rdata=0`; `wr_pulse=0`.
  - `awready=wready=arready=0` while reset is held; all three go to 1 on the first edge with `aresetn=1`.
  - Reset mid-transaction discards any buffered or pending response without completing it.

## Timing
- AW and W accepted on the same edge k → commit at edge k+1 → `bvalid` high after k+1. That is one cycle of write latency after the last of AW/W is accepted.
- A second AW/W may be accepted after commit while `bvalid` is pending; its commit stalls until the edge after `bready` clears `bvalid`.
- Read: AR accepted at edge k → `rvalid` high after k. Throughput is at most one read per 2 cycles when `rready` is tied high.
- Read and write paths are fully independent; both can complete in the same cycle.
- Buffered values are never altered by the master's VALID/data changes after the handshake.

## Test plan
- **Basic write/readback.** Reset 5 cycles, then write addr 0x0000_0004, data 0x1010_1111, strb 4'hF → `bresp=00`, `wr_pulse` with `wr_idx=1`, `reg_q[63:32]=0x1010_1111`. Read 0x4 → `rdata=0x1010_1111`, `rresp=00`.
- **Byte strobes.** Reg 2 = 0xAAAA_BBBB; write 0x0101_0000 with strb 4'b0101 → reg 2 = 0xAA01_BB00.
- **AW/W ordering.** W presented 3 cycles before AW → no commit until AW is accepted, then `bvalid` one cycle later. Repeat with AW before W; `bready` held low 4 cycles → `awready/wready` low for the second transaction and the second commit stalls until B clears.
- **Out-of-range access.** Write to 0x1010_1111 (beyond 16 regs) → `bresp=10`, no `wr_pulse`, all `reg_q` unchanged. Read the same address → `rdata=0`, `rresp=10`.
- **Read/write collision.** Reg 3 = 0x1111_0000; read of reg 3 accepted on the same edge a write of 0x5AA5_A55A to reg 3 commits → `rdata=0x1111_0000`. The next read returns 0x5AA5_A55A.
- **Reset mid-operation.** Assert `aresetn=0` while `bvalid=1` and `rvalid=1` → after the edge both are 0, all registers are 0, and the readies return to 1 one edge after release.
